pac_motion: RTL and testbench
=============================

# pac_motion

Pacman movement and animation controller. Converts debounced direction buttons into Pacman's screen position, facing direction and animation frame once per video frame. Feeds `x_Pac`, `y_Pac`, `pac_Direction` and `pac_Frame` straight into the colour-chooser stage. Outputs are registered and change only on frame ticks, so a sprite never tears mid-scan.

## Interface

Parameters:
- `SPRITE_SCALE`, 2: sprite magnification. Half-extent is H = 8*SPRITE_SCALE.
- `UP`, `DOWN`, `LEFT`, `RIGHT`, 0/1/2/3: 2-bit direction encodings. Must match the colour chooser.
- `X_START`, `Y_START`, 320/240: reset position.
- `SPEED`, 2: pixels moved per frame tick, 1..H.
- `ANIM_DIV`, 4: moving ticks per animation step, ≥1.
- `NUM_FRAMES`, 8: animation frames, 1..8.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse at start of vblank.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced button levels.
- `x_Pac`, `y_Pac` out signed 11: sprite centre.
- `pac_Direction` out 2: facing direction.
- `pac_Frame` out 3: animation frame index.
- `moving` out 1: high while in state MOVE.

## Operation

- Bounds:
  - X_MIN = H-1, X_MAX = 639-H.
  - Y_MIN = H-1, Y_MAX = 479-H.
  - These keep the sprite fully inside 640x480.
- Button priority: UP > DOWN > LEFT > RIGHT.
- Request buffer (`req_dir`, `req_vld`):
  - Any cycle with a button high latches the highest-priority direction and sets `req_vld`.
  - A later press overwrites an earlier one.
  - At a tick, the effective request is that cycle's buttons if any are high, else the latched request.
  - The buffer clears at every tick.
- FSM states: STOP, MOVE. The FSM only advances on `frame_tick`.
- STOP:
  - With a request: `pac_Direction` ← request, step once in that direction, go to MOVE.
  - Without a request: hold all outputs.
- MOVE:
  - A request updates `pac_Direction` first.
  - Then next = position ± SPEED along the direction.
  - If next is outside bounds: clamp to the bound, go to STOP.
  - Otherwise: take next and stay in MOVE.
- Arithmetic: next position is computed in 12-bit signed, so there is no overflow before the compare.
- Animation:
  - A 0..ANIM_DIV-1 counter advances only on ticks where the position actually changed.
  - On wrap, `pac_Frame` ← (`pac_Frame`+1) mod NUM_FRAMES.
  - In STOP, `pac_Frame` and the counter hold.
- Reset values:
  - `x_Pac`=X_START, `y_Pac`=Y_START, `pac_Direction`=RIGHT.
  - `pac_Frame`=0, anim counter 0, `moving`=0.
  - State STOP, request buffer cleared.

## Timing

- All outputs are registered. Updates appear the cycle after the `frame_tick` cycle and are stable between ticks.
- Button-to-motion latency: the next tick. A 1-cycle press anywhere between ticks is honoured.
- `rst` coincident with `frame_tick`: reset wins, tick is dropped.
- `rst` mid-motion: return to reset values on the next edge.
- Request into a wall while already at that bound:
  - Direction updates, position unchanged, stays STOP.
  - Frame holds.
- `frame_tick` held high for multiple cycles is illegal. Each high cycle counts as a tick.

## Configuration

- `PAC_WRAP_EN` defined: horizontal tunnel.
  - Moving LEFT with next < X_MIN sets x = X_MAX. Moving RIGHT with next > X_MAX sets x = X_MIN.
  - State stays MOVE and animation advances.
  - Vertical still clamps.
- Not defined: both axes clamp and go to STOP as above.

## Structure

- Shared package `pac_pkg` holds:
  - direction encodings
  - screen constants 640/480
  - the bound expressions as functions of SPRITE_SCALE
  - the FSM state typedef
- The colour chooser imports the same encodings.
- One sub-module, `pac_anim_counter`:
  - prescaler plus frame counter
  - inputs: `clk`, `rst`, `step`
  - output: `pac_Frame`

## Test plan

All scenarios use defaults, so H=16, X_MIN=15, X_MAX=623, Y_MIN=15, Y_MAX=463.

- Reset → x=320, y=240, dir=3, frame=0, `moving`=0. Ticks with no buttons → all outputs unchanged.
- 1-cycle `btn_right` pulse between ticks → after next tick x=322, `moving`=1. After 4 moving ticks frame=1. After 32 moving ticks frame=0.
- Moving right from x=621:
  - tick → x=623, `moving`=1.
  - tick → x=623, `moving`=0, frame unchanged.
  - With `PAC_WRAP_EN`, the second tick → x=15, `moving`=1.
- `btn_up` and `btn_left` high together in the tick cycle while moving right → dir=0, y=238, x unchanged.
- Stopped at x=623 facing right, press `btn_right` → dir=3, x=623, `moving`=0. Then press `btn_left` → x=621, `moving`=1.
- `rst` in the same cycle as `frame_tick` while moving at x=400 → outputs equal reset values; no step taken.

Source files
------------

// File: rtl/pac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pac_pkg
// Purpose  : Direction encodings, screen limits, sprite bounds and FSM states.
// Revision : 1.0
// ============================================================================
package pac_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_MOVE = 1'b1
  } pac_state_e;

  function automatic int half_ext(input int scale);
    return 8 * scale;
  endfunction

  // Centre limits that keep the whole sprite on screen
  function automatic int x_min(input int scale);
    return half_ext(scale) - 1;
  endfunction

  function automatic int x_max(input int scale);
    return SCREEN_W - 1 - half_ext(scale);
  endfunction

  function automatic int y_min(input int scale);
    return half_ext(scale) - 1;
  endfunction

  function automatic int y_max(input int scale);
    return SCREEN_H - 1 - half_ext(scale);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pac_anim_counter.sv
`default_nettype none
// ============================================================================
// Module   : pac_anim_counter
// Purpose  : Divides position-changing ticks down to an animation frame index.
// Revision : 1.0
// ============================================================================
module pac_anim_counter #(
  parameter int ANIM_DIV   = 4,
  parameter int NUM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [2:0] pac_Frame
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [2:0]    frame_q, frame_d;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (step) begin
      if (div_q == CW'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
      end else begin
        div_d = div_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      frame_q <= 3'd0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign pac_Frame = frame_q;

endmodule
`default_nettype wire

// File: rtl/pac_motion.sv
`default_nettype none
// ============================================================================
// Module   : pac_motion
// Purpose  : Per-frame Pacman position/direction/animation update from buttons.
//            Define PAC_WRAP_EN for a horizontal tunnel instead of clamping.
// Revision : 1.0
// ============================================================================
module pac_motion
  import pac_pkg::*;
#(
  parameter int         SPRITE_SCALE = 2,
  parameter logic [1:0] UP           = DIR_UP,
  parameter logic [1:0] DOWN         = DIR_DOWN,
  parameter logic [1:0] LEFT         = DIR_LEFT,
  parameter logic [1:0] RIGHT        = DIR_RIGHT,
  parameter int         X_START      = 320,
  parameter int         Y_START      = 240,
  parameter int         SPEED        = 2,
  parameter int         ANIM_DIV     = 4,
  parameter int         NUM_FRAMES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic signed [10:0] x_Pac,
  output logic signed [10:0] y_Pac,
  output logic [1:0]         pac_Direction,
  output logic [2:0]         pac_Frame,
  output logic               moving
);

  localparam logic signed [11:0] X_MIN = 12'(x_min(SPRITE_SCALE));
  localparam logic signed [11:0] X_MAX = 12'(x_max(SPRITE_SCALE));
  localparam logic signed [11:0] Y_MIN = 12'(y_min(SPRITE_SCALE));
  localparam logic signed [11:0] Y_MAX = 12'(y_max(SPRITE_SCALE));
  localparam logic signed [11:0] SPD   = 12'(SPEED);

  pac_state_e        state_q, state_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        req_dir_q, req_dir_d;
  logic              req_vld_q, req_vld_d;

  logic              btn_any, eff_vld, step;
  logic [1:0]        btn_dir, eff_dir, mv_dir;
  logic signed [11:0] x12, y12, nx, ny;

  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        btn_dir = UP;
    else if (btn_down) btn_dir = DOWN;
    else if (btn_left) btn_dir = LEFT;
    else               btn_dir = RIGHT;

    // Live buttons in the tick cycle take precedence over the buffered press
    eff_vld = btn_any | req_vld_q;
    eff_dir = btn_any ? btn_dir : req_dir_q;
    mv_dir  = eff_vld ? eff_dir : dir_q;

    req_vld_d = req_vld_q;
    req_dir_d = req_dir_q;
    if (frame_tick) begin
      req_vld_d = 1'b0;
    end else if (btn_any) begin
      req_vld_d = 1'b1;
      req_dir_d = btn_dir;
    end

    x12 = {x_q[10], x_q};
    y12 = {y_q[10], y_q};
    nx  = x12;
    ny  = y12;
    if (mv_dir == UP)        ny = y12 - SPD;
    else if (mv_dir == DOWN) ny = y12 + SPD;
    else if (mv_dir == LEFT) nx = x12 - SPD;
    else                     nx = x12 + SPD;

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    if (frame_tick && (state_q == ST_MOVE || eff_vld)) begin
      dir_d   = mv_dir;
      state_d = ST_MOVE;
      x_d     = nx[10:0];
      y_d     = ny[10:0];
`ifdef PAC_WRAP_EN
      if (nx < X_MIN) x_d = X_MAX[10:0];
      else if (nx > X_MAX) x_d = X_MIN[10:0];
`else
      if (nx < X_MIN) begin
        x_d     = X_MIN[10:0];
        state_d = ST_STOP;
      end else if (nx > X_MAX) begin
        x_d     = X_MAX[10:0];
        state_d = ST_STOP;
      end
`endif
      if (ny < Y_MIN) begin
        y_d     = Y_MIN[10:0];
        state_d = ST_STOP;
      end else if (ny > Y_MAX) begin
        y_d     = Y_MAX[10:0];
        state_d = ST_STOP;
      end
    end

    step = frame_tick & ((x_d != x_q) | (y_d != y_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOP;
      x_q       <= 11'(X_START);
      y_q       <= 11'(Y_START);
      dir_q     <= RIGHT;
      req_dir_q <= RIGHT;
      req_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      req_dir_q <= req_dir_d;
      req_vld_q <= req_vld_d;
    end
  end

  pac_anim_counter #(
    .ANIM_DIV   (ANIM_DIV),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_anim (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .pac_Frame (pac_Frame)
  );

  assign x_Pac         = x_q;
  assign y_Pac         = y_q;
  assign pac_Direction = dir_q;
  assign moving        = (state_q == ST_MOVE);

endmodule
`default_nettype wire

// File: tb/tb_pac_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_pac_motion
// Purpose  : Directed bench with a reference model feeding an expectation queue.
// Revision : 1.0
// ============================================================================
module tb_pac_motion;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic signed [10:0] x_Pac, y_Pac;
  logic [1:0] pac_Direction;
  logic [2:0] pac_Frame;
  logic       moving;

  pac_motion dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .x_Pac         (x_Pac),
    .y_Pac         (y_Pac),
    .pac_Direction (pac_Direction),
    .pac_Frame     (pac_Frame),
    .moving        (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int d;
    int f;
    int m;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: position, direction, frame, divider, moving, request buffer
  int mx, my, md, mf, mc, mm, rv, rd;

  function automatic int pri(input logic [3:0] b);
    if (b[3]) return 0;
    if (b[2]) return 1;
    if (b[1]) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; md = 3; mf = 0; mc = 0; mm = 0; rv = 0; rd = 3;
  endtask

  task automatic model_tick(input logic [3:0] b);
    int ev, ed, nx, ny, nm;
    ev = ((b != 4'b0) || (rv != 0)) ? 1 : 0;
    ed = (b != 4'b0) ? pri(b) : rd;
    rv = 0;
    if (mm == 0 && ev == 0) return;
    if (ev != 0) md = ed;
    nx = mx; ny = my; nm = 1;
    case (md)
      0: ny = my - 2;
      1: ny = my + 2;
      2: nx = mx - 2;
      default: nx = mx + 2;
    endcase
`ifdef PAC_WRAP_EN
    if (nx < 15) nx = 623;
    else if (nx > 623) nx = 15;
`else
    if (nx < 15) begin nx = 15; nm = 0; end
    else if (nx > 623) begin nx = 623; nm = 0; end
`endif
    if (ny < 15) begin ny = 15; nm = 0; end
    else if (ny > 463) begin ny = 463; nm = 0; end
    if (nx != mx || ny != my) begin
      mc = mc + 1;
      if (mc == 4) begin
        mc = 0;
        mf = (mf + 1) % 8;
      end
    end
    mx = nx; my = ny; mm = nm;
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty observed 0 expected 1 entries", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (x_Pac === e.x[10:0]) else begin
        fails++;
        $error("FAIL %s x observed %0d expected %0d", tag, x_Pac, e.x);
      end
      tests++;
      assert (y_Pac === e.y[10:0]) else begin
        fails++;
        $error("FAIL %s y observed %0d expected %0d", tag, y_Pac, e.y);
      end
      tests++;
      assert (pac_Direction === e.d[1:0]) else begin
        fails++;
        $error("FAIL %s dir observed %0d expected %0d", tag, pac_Direction, e.d);
      end
      tests++;
      assert (pac_Frame === e.f[2:0]) else begin
        fails++;
        $error("FAIL %s frame observed %0d expected %0d", tag, pac_Frame, e.f);
      end
      tests++;
      assert (moving === e.m[0]) else begin
        fails++;
        $error("FAIL %s moving observed %0b expected %0d", tag, moving, e.m);
      end
    end
  endtask

  task automatic expect_lit(input string tag, input int x, input int y, input int d,
                            input int f, input int m);
    sb.push_back('{x, y, d, f, m});
    compare(tag);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    drive(b);
    @(negedge clk);
    drive(4'b0);
    rv = 1;
    rd = pri(b);
  endtask

  task automatic tick(input string tag, input logic [3:0] b);
    @(negedge clk);
    drive(b);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    drive(4'b0);
    model_tick(b);
    sb.push_back('{mx, my, md, mf, mm});
    compare(tag);
  endtask

  initial begin
    int px, fh;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_lit("reset", 320, 240, 3, 0, 0);

    repeat (3) tick("idle", 4'b0);
    expect_lit("idle_hold", 320, 240, 3, 0, 0);

    // One-cycle press well before the tick
    repeat (2) @(negedge clk);
    press(4'b0001);
    repeat (3) @(negedge clk);
    tick("pulse_go", 4'b0);
    expect_lit("pulse_go_lit", 322, 240, 3, 0, 1);
    for (int k = 2; k <= 32; k++) begin
      tick("run_right", 4'b0);
      if (k == 4)  expect_lit("frame_one", 328, 240, 3, 1, 1);
      if (k == 32) expect_lit("frame_wrap", 384, 240, 3, 0, 1);
    end

    for (int i = 0; i < 150 && mx < 622; i++) tick("to_wall", 4'b0);
    tick("wall", 4'b0);
`ifdef PAC_WRAP_EN
    expect_lit("tunnel_right", 15, 240, 3, mf, 1);
    tick("tunnel_left", 4'b0010);
    expect_lit("tunnel_left_lit", 623, 240, 2, mf, 1);
`else
    expect_lit("wall_clamp", 623, 240, 3, mf, 0);
    fh = mf;
    tick("stop_hold", 4'b0);
    expect_lit("stop_hold_lit", 623, 240, 3, fh, 0);
    tick("wall_press", 4'b0001);
    expect_lit("wall_press_lit", 623, 240, 3, fh, 0);
`endif
    tick("left_off_wall", 4'b0010);
    expect_lit("left_off_wall_lit", 621, 240, 2, mf, 1);
    tick("right_621", 4'b0001);
    expect_lit("right_621_lit", 623, 240, 3, mf, 1);
    fh = mf;
    tick("edge", 4'b0);
`ifdef PAC_WRAP_EN
    expect_lit("edge_wrap", 15, 240, 3, mf, 1);
`else
    expect_lit("edge_stop", 623, 240, 3, fh, 0);
    tick("re_left", 4'b0010);
    tick("re_right", 4'b0001);
`endif
    px = mx;
    tick("up_left", 4'b1010);
    expect_lit("up_left_lit", px, 238, 0, mf, 1);

    // Reset coincident with a tick while moving at x=400
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    expect_lit("rereset", 320, 240, 3, 0, 0);
    press(4'b0001);
    for (int i = 0; i < 60 && mx < 400; i++) tick("to_400", 4'b0);
    expect_lit("at_400", 400, 240, 3, 2, 1);
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    drive(4'b0001);
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    drive(4'b0);
    model_reset();
    expect_lit("rst_with_tick", 320, 240, 3, 0, 0);
    tick("post_rst_idle", 4'b0);

    // Later press overwrites an earlier higher-priority one
    press(4'b1000);
    press(4'b0010);
    tick("overwrite", 4'b0);
    expect_lit("overwrite_lit", 318, 240, 2, 0, 1);

    tick("down", 4'b0100);
    for (int i = 0; i < 200 && mm != 0; i++) tick("to_floor", 4'b0);
    expect_lit("floor_clamp", 318, 463, 1, mf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
